// File: rtl/vga_scan_pkg.sv
// Shared 640x480@60 Hz raster timing, colour defaults and sync-bundle type
// for the VGA scan generator.
package vga_scan_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   localparam logic [11:0] FG_RGB_DEF = 12'hFFF;
   localparam logic [11:0] BG_RGB_DEF = 12'h000;

   // Bit order used on the delay pipe: {active, hs, vs}
   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
   } sync_t;

   function automatic logic in_window(input logic [11:0] cnt, input int lo, input int width);
      return (cnt >= 12'(lo)) && (cnt < 12'(lo + width));
   endfunction

endpackage

// File: rtl/vga_scan_sync_delay.sv
// Parameterised-depth shift register for the {active, hs, vs} bundle so that
// blanking and sync line up with the renderer's pixel; depth 0 is a wire.
module sync_delay #(
   parameter int         DEPTH   = 1,
   parameter logic [2:0] RST_VAL = 3'b000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [2:0] i_d,
   output logic [2:0] o_q
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic w_unused;
         assign w_unused = i_clk ^ i_rst;
         assign o_q      = i_d;
      end else begin : g_pipe
         logic [2:0] r_pipe [DEPTH];

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               for (int i = 0; i < DEPTH; i++) r_pipe[i] <= RST_VAL;
            end else begin
               r_pipe[0] <= i_d;
               for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
            end
         end

         assign o_q = r_pipe[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_scan.sv
// VGA raster timing generator and output stage: scans the raster, hands the
// coordinate to the renderer and drives aligned RGB/sync plus a frame tick.
module vga_scan
   import vga_scan_pkg::*;
#(
   parameter int          H_ACTIVE      = H_ACTIVE_DEF,
   parameter int          H_FP          = H_FP_DEF,
   parameter int          H_SYNC        = H_SYNC_DEF,
   parameter int          H_BP          = H_BP_DEF,
   parameter int          V_ACTIVE      = V_ACTIVE_DEF,
   parameter int          V_FP          = V_FP_DEF,
   parameter int          V_SYNC        = V_SYNC_DEF,
   parameter int          V_BP          = V_BP_DEF,
   parameter logic        SYNC_ACTIVE   = 1'b0,
   parameter int          PIXEL_LATENCY = 1,
   parameter logic [11:0] FG_RGB        = FG_RGB_DEF,
   parameter logic [11:0] BG_RGB        = BG_RGB_DEF
) (
   input  logic        pixel_clk,
   input  logic        rst,
   input  logic        pixel,
   output logic [11:0] vga_x,
   output logic [11:0] vga_y,
   output logic [11:0] vga_rgb,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        frame_tick
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic SYNC_IDLE = ~SYNC_ACTIVE;

   logic [11:0] r_h_cnt;
   logic [11:0] r_v_cnt;
   sync_t       w_sync_p0;
   sync_t       w_sync_p1;

   // Stage 0: raster counters
   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (r_h_cnt == 12'(H_TOTAL - 1)) begin
         r_h_cnt <= '0;
         r_v_cnt <= (r_v_cnt == 12'(V_TOTAL - 1)) ? '0 : r_v_cnt + 12'd1;
      end else begin
         r_h_cnt <= r_h_cnt + 12'd1;
      end
   end

   assign vga_x = r_h_cnt;
   assign vga_y = r_v_cnt;

   assign w_sync_p0.active = (r_h_cnt < 12'(H_ACTIVE)) && (r_v_cnt < 12'(V_ACTIVE));
   assign w_sync_p0.hs     = in_window(r_h_cnt, H_ACTIVE + H_FP, H_SYNC) ? SYNC_ACTIVE : SYNC_IDLE;
   assign w_sync_p0.vs     = in_window(r_v_cnt, V_ACTIVE + V_FP, V_SYNC) ? SYNC_ACTIVE : SYNC_IDLE;

   // Stage 1: delay blanking/sync by the renderer latency
   sync_delay #(
      .DEPTH   (PIXEL_LATENCY),
      .RST_VAL ({1'b0, SYNC_IDLE, SYNC_IDLE})
   ) u_sync_delay (
      .i_clk (pixel_clk),
      .i_rst (rst),
      .i_d   (w_sync_p0),
      .o_q   (w_sync_p1)
   );

   // Stage 2: output registers, pixel and delayed sync sampled together
   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         vga_rgb    <= '0;
         vga_hs     <= SYNC_IDLE;
         vga_vs     <= SYNC_IDLE;
         frame_tick <= 1'b0;
      end else begin
         vga_rgb    <= w_sync_p1.active ? (pixel ? FG_RGB : BG_RGB) : 12'h000;
         vga_hs     <= w_sync_p1.hs;
         vga_vs     <= w_sync_p1.vs;
         frame_tick <= (r_h_cnt == '0) && (r_v_cnt == 12'(V_ACTIVE));
      end
   end

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan on a shrunken raster: a raster model indexed by cycle
// number predicts every output each cycle, with literal timing pins on top.
module tb_vga_scan;

   localparam int HA = 20, HF = 4, HS = 6, HB = 5, HT = HA + HF + HS + HB;
   localparam int VA = 12, VF = 2, VS = 3, VB = 4, VT = VA + VF + VS + VB;
   localparam int LAT   = 1;
   localparam int FRAME = HT * VT;
   localparam logic [11:0] FG = 12'hFFF;
   localparam logic [11:0] BG = 12'h000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pixel = 1'b1;
   logic [11:0] vga_x, vga_y, vga_rgb;
   logic        vga_hs, vga_vs, frame_tick;

   always #5 clk = ~clk;

   vga_scan #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_ACTIVE(1'b0), .PIXEL_LATENCY(LAT), .FG_RGB(FG), .BG_RGB(BG)
   ) dut (
      .pixel_clk (clk),
      .rst       (rst),
      .pixel     (pixel),
      .vga_x     (vga_x),
      .vga_y     (vga_y),
      .vga_rgb   (vga_rgb),
      .vga_hs    (vga_hs),
      .vga_vs    (vga_vs),
      .frame_tick(frame_tick)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int k     = 0;
   int seg   = 1;
   bit rst_last = 1'b1;
   bit pix_hist [8192];

   int first_hs = -1, first_hs2 = -1, first_vs = -1;
   int hs_cnt = 0, vs_cnt = 0, fff1 = 0, fff3 = 0;
   int rgb112 = -1;
   int ticks1[$];
   int ticks2[$];

   function automatic int hof(int j); return (j % FRAME) % HT; endfunction
   function automatic int vof(int j); return (j % FRAME) / HT; endfunction
   function automatic bit act(int j); return hof(j) < HA && vof(j) < VA; endfunction
   function automatic bit hsx(int j);
      return !(hof(j) >= HA + HF && hof(j) < HA + HF + HS);
   endfunction
   function automatic bit vsx(int j);
      return !(vof(j) >= VA + VF && vof(j) < VA + VF + VS);
   endfunction

   // Renderer stand-in: pixel for coordinate index j of segment s
   function automatic bit pat(int s, int j);
      if (s == 1 && j < 2 * FRAME) return hof(j) == 5 && vof(j) == 3;
      if (s == 1 && j < 3 * FRAME) return 1'b1;
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic chk(string nm, int a, int e);
      n_cmp++;
      if (a != e) begin
         n_bad++;
         $display("FAIL %s k=%0d seg=%0d got %0h want %0h", nm, k, seg, a, e);
      end
   endtask

   always @(negedge clk) begin
      int          j;
      logic [11:0] e_rgb;
      bit          e_hs, e_vs, e_tick;

      if (rst_last) k = 0;
      else          k = k + 1;

      if (k >= LAT + 1) begin
         j     = k - 1 - LAT;
         e_rgb = act(j) ? (pix_hist[k-1] ? FG : BG) : 12'h000;
         e_hs  = hsx(j);
         e_vs  = vsx(j);
      end else begin
         e_rgb = 12'h000;
         e_hs  = 1'b1;
         e_vs  = 1'b1;
      end
      e_tick = (k >= 1) && hof(k - 1) == 0 && vof(k - 1) == VA;

      chk("x",    int'(vga_x),      hof(k));
      chk("y",    int'(vga_y),      vof(k));
      chk("rgb",  int'(vga_rgb),    int'(e_rgb));
      chk("hs",   int'(vga_hs),     int'(e_hs));
      chk("vs",   int'(vga_vs),     int'(e_vs));
      chk("tick", int'(frame_tick), int'(e_tick));

      if (seg == 1) begin
         if (vga_hs == 1'b0 && first_hs < 0) first_hs = k;
         if (k >= 2 && k < 2 + HT && vga_hs == 1'b0) hs_cnt++;
         if (vga_vs == 1'b0 && first_vs < 0) first_vs = k;
         if (k >= 2 && k < 2 + FRAME && vga_vs == 1'b0) vs_cnt++;
         if (frame_tick) ticks1.push_back(k);
         if (k >= 2 && k < 2 + FRAME && vga_rgb == 12'hFFF) fff1++;
         if (k == 112) rgb112 = int'(vga_rgb);
         if (k >= 2 + 2 * FRAME && k < 2 + 3 * FRAME && vga_rgb == 12'hFFF) fff3++;
      end else begin
         if (vga_hs == 1'b0 && first_hs2 < 0) first_hs2 = k;
         if (frame_tick) ticks2.push_back(k);
      end

      if (rst || k - LAT < 0) pixel = 1'b1;
      else                    pixel = pat(seg, k - LAT);
      if (k < 8192) pix_hist[k] = pixel;
      rst_last = rst;
   end

   initial begin
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      // Run to coordinate (10,5) of the fifth frame, then reset mid-frame
      for (int i = 0; i < 6000 && k != 3124; i++) begin
         @(posedge clk);
         #2;
      end
      if (k != 3124) begin
         n_cmp++;
         n_bad++;
         $display("FAIL midrst_wait got k=%0d want 3124", k);
      end
      rst = 1'b1;
      seg = 2;
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (800) @(posedge clk);
      #2;

      chk("first_hs",  first_hs, 26);
      chk("hs_width",  hs_cnt,   HS);
      chk("first_vs",  first_vs, 492);
      chk("vs_width",  vs_cnt,   105);
      chk("tick_cnt",  ticks1.size(), 4);
      chk("tick0",     ticks1.size() > 0 ? ticks1[0] : -1, 421);
      chk("tick1",     ticks1.size() > 1 ? ticks1[1] : -1, 1156);
      chk("dot_count", fff1,   1);
      chk("dot_5_3",   rgb112, 12'hFFF);
      chk("tied1_cnt", fff3,   240);
      chk("rst_hs",    first_hs2, 26);
      chk("rst_tick",  ticks2.size() > 0 ? ticks2[0] : -1, 421);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
